bist_and_or_cascade: RTL and testbench
======================================

// Module: bist_and_or_cascade
// PURPOSE
//  Parametrised, registered successor to our AND2/OR2 cascade cell network.
//  The core evaluates an N_IN-input prefix-AND / OR cascade. It has a 1-cycle registered functional path.
//  A built-in self-test (BIST) engine drives the core from an LFSR and compacts its outputs in a MISR.
//  The block sits between the functional inputs and the downstream netlist, and is selected by bist_start.
// PARAMETERS
//  N_IN      4            core input width, >=2; also LFSR width
//  SIG_W     16           MISR signature width, >=2
//  PATTERNS  15           LFSR patterns applied per BIST run, 1..2^N_IN-1
//  SEED      4'b0001      LFSR load value, width N_IN, must be nonzero
//  LFSR_TAP  4'b1001      LFSR feedback taps, width N_IN (bit i = stage i)
//  MISR_TAP  16'h8016     MISR feedback taps, width SIG_W
//  GOLDEN    16'h0000     expected signature, width SIG_W
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  func_in    in   N_IN   functional operand
//  func_vld   in   1      func_in valid
//  func_out   out  1      registered core result
//  func_ovld  out  1      func_out valid
//  bist_start in   1      1-cycle pulse; starts a BIST run from IDLE or DONE
//  bist_abort in   1      returns to IDLE from any state
//  bist_busy  out  1      1 in RUN and FLUSH
//  bist_done  out  1      1 in DONE
//  bist_pass  out  1      valid while bist_done: signature == GOLDEN
//  bist_sig   out  SIG_W  current MISR contents
// BEHAVIOUR
//  Core function, combinational, for core input x:
//   - p1 = x0&x1, pk = p(k-1)&xk.
//   - y = x0 | p1 | p2 | ... | p(N-2) | x(N-1), which reduces to x0|x(N-1).
//   - Build the core as explicit AND2/OR2 stages.
//  Reset values: all outputs 0; FSM=IDLE; LFSR=SEED; MISR=0; cnt=0.
//  Functional path: allowed only in IDLE or DONE.
//   - func_out <= y(func_in) on every edge.
//   - func_ovld <= func_vld.
//   - Latency is 1 cycle with full throughput.
//   - In RUN or FLUSH, func_ovld=0 and func_out holds its value.
//  FSM states: IDLE, RUN, FLUSH, DONE.
//   - IDLE/DONE --bist_start--> RUN: LFSR<=SEED, MISR<=0, cnt<=0, done<=0.
//   - RUN: core input is LFSR.
//     - Each cycle: yreg<=y(LFSR), LFSR steps, cnt++.
//     - MISR absorbs yreg from the 2nd RUN cycle on.
//     - When cnt==PATTERNS-1, go to FLUSH.
//   - FLUSH (1 cycle): MISR absorbs the final yreg, then go to DONE.
//   - DONE: bist_done=1, bist_pass=(MISR==GOLDEN). Hold until bist_start or bist_abort.
//   - bist_start while busy is ignored.
//   - bist_abort takes priority over bist_start.
//     - Next state IDLE, done=0, pass=0.
//     - LFSR, MISR and cnt return to reset values.
//  LFSR step (Fibonacci): fb = ^(LFSR & LFSR_TAP); LFSR <= {LFSR[N_IN-2:0], fb}.
//  MISR step: fb = ^(MISR & MISR_TAP); MISR <= {MISR[SIG_W-2:0], fb ^ yreg}.
//  Run length: exactly PATTERNS core evaluations and PATTERNS MISR updates.
//   - start-to-done is PATTERNS+1 cycles after the bist_start edge.
//  Asynchronous reset mid-run: immediate return to IDLE; no partial done/pass.
// TESTING
//  T1: reset, then func_vld=1 with func_in=4'b0001, 4'b1000, 4'b0110 -> func_out 1,1,0 one cycle later; func_ovld tracks func_vld.
//  T2: bist_start pulse -> bist_busy high for exactly PATTERNS+1=16 cycles, then bist_done=1 and the counts match the model.
//  T3: run BIST, read bist_sig -> equals the bench model. Rerun with GOLDEN=that value -> bist_pass=1; GOLDEN^1 -> bist_pass=0.
//  T4: pulse bist_start again during RUN -> ignored; run length and signature unchanged.
//  T5: bist_abort at RUN cycle 5 -> IDLE next cycle, busy=0, done=0, bist_sig=0; the next start gives the full-run signature.
//  T6: deassert rst_n asynchronously mid-run -> all outputs 0 without a clock edge; func path works after release.

Source files
------------

// File: rtl/bist_and_or_cascade.sv
// Registered prefix-AND / OR cascade core with an LFSR/MISR built-in self-test engine.
// The functional path is live only while the BIST engine is idle or done.
module bist_and_or_cascade #(
    parameter int unsigned         N_IN     = 4,
    parameter int unsigned         SIG_W    = 16,
    parameter int unsigned         PATTERNS = 15,
    parameter logic [N_IN-1:0]     SEED     = 4'b0001,
    parameter logic [N_IN-1:0]     LFSR_TAP = 4'b1001,
    parameter logic [SIG_W-1:0]    MISR_TAP = 16'h8016,
    parameter logic [SIG_W-1:0]    GOLDEN   = 16'h0000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IN-1:0]  i_func_in,
    input  logic             i_func_vld,
    output logic             o_func_out,
    output logic             o_func_ovld,
    input  logic             i_bist_start,
    input  logic             i_bist_abort,
    output logic             o_bist_busy,
    output logic             o_bist_done,
    output logic             o_bist_pass,
    output logic [SIG_W-1:0] o_bist_sig
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [N_IN-1:0] CNT_LAST = N_IN'(PATTERNS - 1);

    state_e            r_state, w_state_nxt;
    logic [N_IN-1:0]   r_lfsr, w_lfsr_nxt;
    logic [SIG_W-1:0]  r_misr, w_misr_nxt;
    logic [N_IN-1:0]   r_cnt, w_cnt_nxt;
    logic              r_yreg, w_yreg_nxt;
    logic              r_func_out, w_func_out_nxt;
    logic              r_func_ovld, w_func_ovld_nxt;

    logic [N_IN-1:0]   w_core_x;
    logic [N_IN-2:0]   w_and;
    logic [N_IN-2:0]   w_or;
    logic              w_y;
    logic [N_IN-1:0]   w_lfsr_step;
    logic [SIG_W-1:0]  w_misr_step;

    assign w_core_x = (r_state == StRun) ? r_lfsr : i_func_in;

    // Stage k: w_and[k] = p(k), w_or[k] = x0 | p1 | ... | p(k).
    always_comb begin
        w_and    = '0;
        w_or     = '0;
        w_and[0] = w_core_x[0];
        w_or[0]  = w_core_x[0];
        for (int k = 1; k <= int'(N_IN) - 2; k++) begin
            w_and[k] = w_and[k-1] & w_core_x[k];
            w_or[k]  = w_or[k-1] | w_and[k];
        end
    end

    assign w_y         = w_or[N_IN-2] | w_core_x[N_IN-1];
    assign w_lfsr_step = {r_lfsr[N_IN-2:0], ^(r_lfsr & LFSR_TAP)};
    assign w_misr_step = {r_misr[SIG_W-2:0], (^(r_misr & MISR_TAP)) ^ r_yreg};

    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_misr_nxt      = r_misr;
        w_cnt_nxt       = r_cnt;
        w_yreg_nxt      = r_yreg;
        w_func_out_nxt  = r_func_out;
        w_func_ovld_nxt = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                w_func_out_nxt  = w_y;
                w_func_ovld_nxt = i_func_vld;
                if (i_bist_start) begin
                    w_state_nxt = StRun;
                    w_lfsr_nxt  = SEED;
                    w_misr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            end
            StRun: begin
                w_yreg_nxt = w_y;
                w_lfsr_nxt = w_lfsr_step;
                w_cnt_nxt  = r_cnt + 1'b1;
                // yreg is stale on the first RUN cycle
                if (r_cnt != '0) begin
                    w_misr_nxt = w_misr_step;
                end
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = StFlush;
                end
            end
            StFlush: begin
                w_misr_nxt  = w_misr_step;
                w_state_nxt = StDone;
            end
            default: w_state_nxt = StIdle;
        endcase
        if (i_bist_abort) begin
            w_state_nxt = StIdle;
            w_lfsr_nxt  = SEED;
            w_misr_nxt  = '0;
            w_cnt_nxt   = '0;
            w_yreg_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_lfsr      <= SEED;
            r_misr      <= '0;
            r_cnt       <= '0;
            r_yreg      <= 1'b0;
            r_func_out  <= 1'b0;
            r_func_ovld <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_misr      <= w_misr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_yreg      <= w_yreg_nxt;
            r_func_out  <= w_func_out_nxt;
            r_func_ovld <= w_func_ovld_nxt;
        end
    end

    assign o_func_out  = r_func_out;
    assign o_func_ovld = r_func_ovld;
    assign o_bist_busy = (r_state == StRun) || (r_state == StFlush);
    assign o_bist_done = (r_state == StDone);
    assign o_bist_pass = (r_state == StDone) && (r_misr == GOLDEN);
    assign o_bist_sig  = r_misr;

endmodule

// File: tb/tb_bist_and_or_cascade.sv
// Directed bench for bist_and_or_cascade: functional path, BIST length/signature,
// golden compare, restart-while-busy, abort and asynchronous reset.
module tb_bist_and_or_cascade;

    localparam int unsigned  N_IN     = 4;
    localparam int unsigned  SIG_W    = 16;
    localparam int unsigned  PATTERNS = 15;
    localparam logic [3:0]   SEED     = 4'b0001;
    localparam logic [3:0]   LFSR_TAP = 4'b1001;
    localparam logic [15:0]  MISR_TAP = 16'h8016;

    // Reference signature: core reduces to x0 | x3.
    function automatic logic [15:0] model_sig();
        logic [3:0]  l;
        logic [15:0] m;
        logic        yr;
        l  = SEED;
        m  = '0;
        yr = 1'b0;
        for (int i = 0; i < int'(PATTERNS); i++) begin
            if (i > 0) m = {m[14:0], (^(m & MISR_TAP)) ^ yr};
            yr = l[0] | l[3];
            l  = {l[2:0], ^(l & LFSR_TAP)};
        end
        m = {m[14:0], (^(m & MISR_TAP)) ^ yr};
        return m;
    endfunction

    localparam logic [15:0] MODEL = model_sig();

    logic             clk;
    logic             rst_n;
    logic [3:0]       func_in;
    logic             func_vld;
    logic             bist_start;
    logic             bist_abort;
    logic [2:0]       func_out, func_ovld, busy, done, pass;
    logic [15:0]      sig [3];

    int n_pass  = 0;
    int n_total = 0;
    logic [1:0]  fq [$];
    logic [15:0] sq [$];

    bist_and_or_cascade #(.N_IN(N_IN), .SIG_W(SIG_W), .PATTERNS(PATTERNS), .SEED(SEED),
        .LFSR_TAP(LFSR_TAP), .MISR_TAP(MISR_TAP), .GOLDEN(16'h0000)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_func_in(func_in), .i_func_vld(func_vld),
        .o_func_out(func_out[0]), .o_func_ovld(func_ovld[0]), .i_bist_start(bist_start),
        .i_bist_abort(bist_abort), .o_bist_busy(busy[0]), .o_bist_done(done[0]),
        .o_bist_pass(pass[0]), .o_bist_sig(sig[0]));

    bist_and_or_cascade #(.N_IN(N_IN), .SIG_W(SIG_W), .PATTERNS(PATTERNS), .SEED(SEED),
        .LFSR_TAP(LFSR_TAP), .MISR_TAP(MISR_TAP), .GOLDEN(MODEL)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_func_in(func_in), .i_func_vld(func_vld),
        .o_func_out(func_out[1]), .o_func_ovld(func_ovld[1]), .i_bist_start(bist_start),
        .i_bist_abort(bist_abort), .o_bist_busy(busy[1]), .o_bist_done(done[1]),
        .o_bist_pass(pass[1]), .o_bist_sig(sig[1]));

    bist_and_or_cascade #(.N_IN(N_IN), .SIG_W(SIG_W), .PATTERNS(PATTERNS), .SEED(SEED),
        .LFSR_TAP(LFSR_TAP), .MISR_TAP(MISR_TAP), .GOLDEN(MODEL ^ 16'h0001)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_func_in(func_in), .i_func_vld(func_vld),
        .o_func_out(func_out[2]), .o_func_ovld(func_ovld[2]), .i_bist_start(bist_start),
        .i_bist_abort(bist_abort), .o_bist_busy(busy[2]), .o_bist_done(done[2]),
        .o_bist_pass(pass[2]), .o_bist_sig(sig[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_func_out"}, 32'(func_out[i]), 32'd0);
            check({tag, "_func_ovld"}, 32'(func_ovld[i]), 32'd0);
            check({tag, "_busy"}, 32'(busy[i]), 32'd0);
            check({tag, "_done"}, 32'(done[i]), 32'd0);
            check({tag, "_pass"}, 32'(pass[i]), 32'd0);
            check({tag, "_sig"}, 32'(sig[i]), 32'd0);
        end
    endtask

    task automatic drive_func(input logic [3:0] x, input logic v);
        logic [1:0] e;
        func_in  = x;
        func_vld = v;
        fq.push_back({x[0] | x[3], v});
        tick();
        e = fq.pop_front();
        check("func_out", 32'(func_out[0]), 32'(e[1]));
        check("func_ovld", 32'(func_ovld[0]), 32'(e[0]));
    endtask

    task automatic start_bist(input bit expect_full);
        if (expect_full) sq.push_back(MODEL);
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
    endtask

    task automatic wait_done(input int already, input bit hold_chk);
        int len;
        logic [15:0] e;
        len = already;
        while (busy[0] && len < 100) begin
            tick();
            len++;
            if (hold_chk && len == 3) begin
                check("run_func_ovld", 32'(func_ovld[0]), 32'd0);
                check("run_func_hold", 32'(func_out[0]), 32'd0);
            end
        end
        e = sq.pop_front();
        check("run_length", 32'(len), 32'(PATTERNS + 1));
        check("done", 32'(done[0]), 32'd1);
        check("busy_after", 32'(busy[0]), 32'd0);
        check("sig", 32'(sig[0]), 32'(e));
        check("pass_golden0", 32'(pass[0]), 32'(e == 16'h0000));
        check("pass_golden_model", 32'(pass[1]), 32'd1);
        check("pass_golden_flip", 32'(pass[2]), 32'd0);
        check("done_flip", 32'(done[2]), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        func_in    = '0;
        func_vld   = 1'b0;
        bist_start = 1'b0;
        bist_abort = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Functional path, full throughput
        drive_func(4'b0001, 1'b1);
        drive_func(4'b1000, 1'b1);
        drive_func(4'b0110, 1'b1);
        drive_func(4'b1001, 1'b0);
        drive_func(4'b0100, 1'b1);

        // Full run; functional inputs change mid-run and must not leak through
        func_in  = 4'b0110;
        func_vld = 1'b1;
        start_bist(1'b1);
        func_in  = 4'b1001;
        wait_done(0, 1'b1);
        drive_func(4'b1001, 1'b1);
        drive_func(4'b0110, 1'b0);

        // Restart from DONE with a stray start pulse during RUN
        start_bist(1'b1);
        repeat (3) tick();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        wait_done(4, 1'b0);

        // Abort during the fifth RUN cycle
        start_bist(1'b0);
        repeat (4) tick();
        bist_abort = 1'b1;
        tick();
        bist_abort = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_sig", 32'(sig[0]), 32'd0);
        start_bist(1'b1);
        wait_done(0, 1'b0);

        // Asynchronous reset mid-run
        start_bist(1'b0);
        repeat (6) tick();
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #2 rst_n = 1'b1;
        drive_func(4'b1000, 1'b1);
        drive_func(4'b0110, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
